// File: rtl/adder_pkg.sv
// -----------------------------------------------------------------------------
// adder_pkg
// Shared types and default sizing for the EX-stage add/sub unit. The ALU and
// the flags register use the same definitions.
//   ADDER_WIDTH   default operand/result width
//   ADDER_STAGES  default pipeline depth (number of carry chunks)
//   adder_flags_t ARM-style NZCV flag bundle
// -----------------------------------------------------------------------------
package adder_pkg;

    localparam int ADDER_WIDTH  = 64;
    localparam int ADDER_STAGES = 4;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } adder_flags_t;

endpackage

// File: rtl/pipelined_adder_if.sv
// -----------------------------------------------------------------------------
// pipelined_adder_if
// Operation/result handshake bundle for pipelined_adder.
//   in_valid/in_ready    operation handshake (a, b, sub)
//   out_valid/out_ready  result handshake (result, flag_n/z/c/v)
// modport master: the issuing side (drives operations, consumes results)
// modport slave : the adder itself
// -----------------------------------------------------------------------------
interface pipelined_adder_if
    import adder_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             flag_n;
    logic             flag_z;
    logic             flag_c;
    logic             flag_v;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, result, flag_n, flag_z, flag_c, flag_v
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, result, flag_n, flag_z, flag_c, flag_v
    );

endinterface

// File: rtl/adder_chunk.sv
// -----------------------------------------------------------------------------
// adder_chunk
// Combinational CW-bit ripple-carry adder built from fullAdder cells.
//   i_a, i_b           chunk operands
//   i_cin              carry into bit 0
//   o_sum              CW-bit sum
//   o_cout             carry out of the chunk MSB
//   o_carry_into_msb   carry into the chunk MSB (for signed overflow)
// -----------------------------------------------------------------------------
module adder_chunk #(
    parameter int  CW    = 16,
    parameter real DELAY = 0.5
) (
    input  logic [CW-1:0] i_a,
    input  logic [CW-1:0] i_b,
    input  logic          i_cin,
    output logic [CW-1:0] o_sum,
    output logic          o_cout,
    output logic          o_carry_into_msb
);

    logic [CW:0] w_carry;

    assign w_carry[0] = i_cin;

    for (genvar i = 0; i < CW; i++) begin : g_fa
        fullAdder #(
            .DELAY (DELAY)
        ) u_fa (
            .i_a    (i_a[i]),
            .i_b    (i_b[i]),
            .i_cin  (w_carry[i]),
            .o_sum  (o_sum[i]),
            .o_cout (w_carry[i+1])
        );
    end

    assign o_cout           = w_carry[CW];
    assign o_carry_into_msb = w_carry[CW-1];

endmodule

// File: rtl/fullAdder.sv
// -----------------------------------------------------------------------------
// fullAdder
// One-bit full adder primitive used to build the ripple chunks.
//   i_a, i_b  addend bits
//   i_cin     carry in
//   o_sum     sum bit
//   o_cout    carry out
// DELAY is the nominal gate delay in ns carried for timing annotation; the
// logic itself is delay-free.
// -----------------------------------------------------------------------------
module fullAdder #(
    parameter real DELAY = 0.5
) (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    if (DELAY < 0.0) begin : g_bad_delay
        $fatal(1, "fullAdder: DELAY must be non-negative");
    end

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule

// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
// Pipelined add/subtract unit for the EX stage. The operand is split into
// STAGES chunks of CW = WIDTH/STAGES bits; each pipeline stage ripples one
// chunk and registers its carry for the next stage. Produces NZCV flags.
//   clk      rising-edge clock
//   reset    synchronous, active-high; clears valids, result and flags
//   bus      pipelined_adder_if.slave:
//              in_valid/in_ready, a, b, sub       operation input
//              out_valid/out_ready, result, flag_n/z/c/v   result output
// Latency is STAGES cycles; one operation per cycle; a single global stall
// (advance) freezes every stage when the output is held.
// -----------------------------------------------------------------------------
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int  WIDTH  = ADDER_WIDTH,
    parameter int  STAGES = ADDER_STAGES,
    parameter real DELAY  = 0.5
) (
    input  logic              clk,
    input  logic              reset,
    pipelined_adder_if.slave  bus
);

    localparam int CW   = WIDTH / STAGES;
    // Intermediate (non-output) stage count; kept at least 1 so the arrays
    // stay legal for the single-stage build.
    localparam int NMID = (STAGES > 1) ? STAGES - 1 : 1;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_param_check
        $fatal(1, "pipelined_adder: WIDTH must be a positive multiple of STAGES");
    end

    // Result chunks are assembled by shifting: each stage drops the oldest
    // chunk position and inserts its new chunk at the top, so after STAGES
    // stages chunk 0 lands at bit 0.
    function automatic logic [WIDTH-1:0] place_chunk(
        input logic [WIDTH-1:0] prev,
        input logic [CW-1:0]    chunk
    );
        return (prev >> CW) | (WIDTH'(chunk) << (WIDTH - CW));
    endfunction

    logic             w_advance;
    logic [WIDTH-1:0] w_b_eff;

    // Per-stage chunk inputs/outputs
    logic [WIDTH-1:0] w_src_a    [STAGES];
    logic [WIDTH-1:0] w_src_b    [STAGES];
    logic [WIDTH-1:0] w_sum_prev [STAGES];
    logic             w_cin      [STAGES];
    logic [CW-1:0]    w_sum      [STAGES];
    logic             w_cout     [STAGES];
    logic             w_cmsb     [STAGES];

    logic [WIDTH-1:0] w_result;
    adder_flags_t     w_flags;

    // Stage registers: valids for every stage, data for the intermediate
    // stages, and the output register for the last stage.
    logic [STAGES-1:0] r_vld;
    logic [WIDTH-1:0]  r_opa  [NMID];
    logic [WIDTH-1:0]  r_opb  [NMID];
    logic [WIDTH-1:0]  r_part [NMID];
    logic              r_cy   [NMID];
    logic [WIDTH-1:0]  r_result;
    adder_flags_t      r_flags;

    assign w_advance = ~r_vld[STAGES-1] | bus.out_ready;
    assign w_b_eff   = bus.sub ? ~bus.b : bus.b;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign w_src_a[k]    = bus.a;
            assign w_src_b[k]    = w_b_eff;
            assign w_cin[k]      = bus.sub;
            assign w_sum_prev[k] = '0;
        end else begin : g_next
            // Operands were shifted down on entry, so this stage's chunk
            // is always the low CW bits.
            assign w_src_a[k]    = r_opa[k-1];
            assign w_src_b[k]    = r_opb[k-1];
            assign w_cin[k]      = r_cy[k-1];
            assign w_sum_prev[k] = r_part[k-1];
        end

        adder_chunk #(
            .CW    (CW),
            .DELAY (DELAY)
        ) u_chunk (
            .i_a              (w_src_a[k][CW-1:0]),
            .i_b              (w_src_b[k][CW-1:0]),
            .i_cin            (w_cin[k]),
            .o_sum            (w_sum[k]),
            .o_cout           (w_cout[k]),
            .o_carry_into_msb (w_cmsb[k])
        );
    end

    assign w_result  = place_chunk(w_sum_prev[STAGES-1], w_sum[STAGES-1]);
    assign w_flags.n = w_result[WIDTH-1];
    assign w_flags.z = (w_result == '0);
    assign w_flags.c = w_cout[STAGES-1];
    assign w_flags.v = w_cout[STAGES-1] ^ w_cmsb[STAGES-1];

    // Control and output stage: valids, result and flags
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld    <= '0;
            r_result <= '0;
            r_flags  <= '0;
        end else if (w_advance) begin
            r_vld[0] <= bus.in_valid;
            for (int k = 1; k < STAGES; k++) begin
                r_vld[k] <= r_vld[k-1];
            end
            r_result <= w_result;
            r_flags  <= w_flags;
        end
    end

    // Intermediate stage boundaries: remaining operands, partial result, carry
    always_ff @(posedge clk) begin
        if (w_advance) begin
            for (int k = 0; k < STAGES - 1; k++) begin
                r_opa[k]  <= w_src_a[k] >> CW;
                r_opb[k]  <= w_src_b[k] >> CW;
                r_part[k] <= place_chunk(w_sum_prev[k], w_sum[k]);
                r_cy[k]   <= w_cout[k];
            end
        end
    end

    assign bus.in_ready  = w_advance;
    assign bus.out_valid = r_vld[STAGES-1];
    assign bus.result    = r_result;
    assign bus.flag_n    = r_flags.n;
    assign bus.flag_z    = r_flags.z;
    assign bus.flag_c    = r_flags.c;
    assign bus.flag_v    = r_flags.v;

endmodule

// File: tb/tb_pipelined_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_adder
// Scoreboard bench for pipelined_adder (WIDTH=64, STAGES=4). A driver pushes
// the expected response when an operation is accepted; an independent monitor
// pops and compares whenever a result is taken.
// -----------------------------------------------------------------------------
module tb_pipelined_adder;
    import adder_pkg::*;

    localparam int W = 64;
    localparam int S = 4;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   nzcv;
        int           acc;
        bit           chk_lat;
    } exp_t;

    logic clk;
    logic reset;

    int   checks     = 0;
    int   failures   = 0;
    int   cyc        = 0;
    bit   mon_en     = 0;
    bit   stall_mode = 0;
    bit   rand_done  = 0;
    exp_t sb[$];

    logic [W-1:0] ra, rb;
    logic         rs;

    bit           prev_stall = 0;
    logic [W-1:0] prev_res;
    logic [3:0]   prev_fl;
    exp_t         mon_e;

    pipelined_adder_if #(.WIDTH(W)) bus ();

    pipelined_adder #(
        .WIDTH  (W),
        .STAGES (S),
        .DELAY  (0.5)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    // Reference: plain modular arithmetic and the textbook flag definitions.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
        exp_t       e;
        logic [W:0] wide;
        logic       c, v;
        if (!s) begin
            wide  = {1'b0, a} + {1'b0, b};
            e.res = wide[W-1:0];
            c     = wide[W];
            v     = (a[W-1] == b[W-1]) && (e.res[W-1] != a[W-1]);
        end else begin
            e.res = a - b;
            c     = (a >= b);
            v     = (a[W-1] != b[W-1]) && (e.res[W-1] != a[W-1]);
        end
        e.nzcv    = {e.res[W-1], (e.res == '0), c, v};
        e.acc     = 0;
        e.chk_lat = 0;
        return e;
    endfunction

    function automatic exp_t mk(input logic [W-1:0] res, input logic [3:0] nzcv);
        exp_t e;
        e.res     = res;
        e.nzcv    = nzcv;
        e.acc     = 0;
        e.chk_lat = 0;
        return e;
    endfunction

    function automatic logic [W-1:0] rnd_op();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0:       v = '0;
            1:       v = '1;
            2:       v = {1'b0, {(W-1){1'b1}}};
            3:       v = {1'b1, {(W-1){1'b0}}};
            4:       v = W'($urandom_range(0, 3));
            default: v = {$urandom(), $urandom()};
        endcase
        return v;
    endfunction

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic s, input exp_t e);
        int n    = 0;
        bit done = 0;
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.sub      = s;
        while (!done) begin
            @(negedge clk);
            if (bus.in_ready) begin
                e.acc     = cyc;
                e.chk_lat = !stall_mode;
                sb.push_back(e);
                done = 1;
            end else if (n++ >= 200) begin
                checks++;
                failures++;
                $display("FAIL send_timeout: in_ready=0 for 200 cycles, required 1");
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        chk("drain_empty", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: pops on every taken result, checks hold and in_ready rule.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            if (prev_stall) begin
                chk("hold_valid", 64'(bus.out_valid), 64'd1);
                chk("hold_result", bus.result, prev_res);
                chk("hold_flags", 64'({bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v}), 64'(prev_fl));
            end
            chk("in_ready_rule", 64'(bus.in_ready), 64'(!bus.out_valid || bus.out_ready));
            if (bus.out_valid && bus.out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_output: got result %h with empty scoreboard, required no output", bus.result);
                end else begin
                    mon_e = sb.pop_front();
                    chk("result", bus.result, mon_e.res);
                    chk("nzcv", 64'({bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v}), 64'(mon_e.nzcv));
                    if (mon_e.chk_lat)
                        chk("latency", 64'(cyc - mon_e.acc), 64'(S));
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_res   = bus.result;
            prev_fl    = {bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v};
        end else begin
            prev_stall = 0;
        end
    end

    initial begin
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.sub       = 1'b0;
        bus.out_ready = 1'b1;

        // Reset state
        @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_result", bus.result, 64'd0);
        chk("rst_flags", 64'({bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v}), 64'd0);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        // Directed corner cases, back-to-back
        send(64'h0000_0000_FFFF_FFFF, 64'd1, 1'b0, mk(64'h0000_0001_0000_0000, 4'b0000));
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, mk(64'h8000_0000_0000_0000, 4'b1001));
        send(64'd5, 64'd5, 1'b1, mk(64'd0, 4'b0110));
        send(64'd0, 64'd1, 1'b1, mk(64'hFFFF_FFFF_FFFF_FFFF, 4'b1000));
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, mk(64'd0, 4'b0110));
        send(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, mk(64'd0, 4'b0111));
        send(64'h8000_0000_0000_0000, 64'd1, 1'b1, mk(64'h7FFF_FFFF_FFFF_FFFF, 4'b0011));
        drain();

        // Back-pressure: 8 ops, out_ready low for 3 cycles after first out_valid
        stall_mode = 1;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    ra = rnd_op();
                    rb = rnd_op();
                    rs = 1'($urandom_range(0, 1));
                    send(ra, rb, rs, model(ra, rb, rs));
                end
            end
            begin
                int n = 0;
                while (!bus.out_valid && n < 100) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                chk("bp_first_valid", 64'(bus.out_valid), 64'd1);
                bus.out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
                    @(posedge clk);
                    #1;
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();
        stall_mode = 0;

        // Reset mid-flight: three ops in flight are discarded
        for (int i = 0; i < 3; i++) begin
            ra = rnd_op();
            rb = rnd_op();
            send(ra, rb, 1'b0, model(ra, rb, 1'b0));
        end
        reset = 1'b1;
        sb.delete();
        bus.in_valid = 1'b1;
        bus.a        = 64'd7;
        bus.b        = 64'd9;
        bus.sub      = 1'b0;
        @(posedge clk);
        #1;
        reset        = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("midrst_result", bus.result, 64'd0);
        chk("midrst_flags", 64'({bus.flag_n, bus.flag_z, bus.flag_c, bus.flag_v}), 64'd0);
        chk("midrst_in_ready", 64'(bus.in_ready), 64'd1);
        repeat (8) @(posedge clk);
        #1;
        send(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0,
             model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0));
        drain();

        // Random stream, no stall: latency checked on every op
        for (int i = 0; i < 40; i++) begin
            ra = rnd_op();
            rb = rnd_op();
            rs = 1'($urandom_range(0, 1));
            send(ra, rb, rs, model(ra, rb, rs));
        end
        drain();

        // Random stream with random gaps and random out_ready
        stall_mode = 1;
        rand_done  = 0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    ra = rnd_op();
                    rb = rnd_op();
                    rs = 1'($urandom_range(0, 1));
                    send(ra, rb, rs, model(ra, rb, rs));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rand_done = 1;
            end
            begin
                while (!rand_done) begin
                    bus.out_ready = ($urandom_range(0, 3) != 0);
                    @(posedge clk);
                    #1;
                end
                bus.out_ready = 1'b1;
            end
        join
        drain();
        stall_mode = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
